// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage MIPS core.
// It tracks in-flight GPR writers in E/M/W and computes the D-stage stall,
// the D/E forwarding selects and the HI/LO (mult/div) busy sequencing.
//
// Handshake: stall acts as the inverse of a D-stage ready. When stall=1 the
// instruction in D is held (PC and F/D frozen) and a bubble enters E. When
// stall=0 the D instruction is accepted on the next rising edge.
module hazard_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs_addr,
  input  logic [4:0] D_rt_addr,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic [1:0] D_fwd_rs_sel,
  output logic [1:0] D_fwd_rt_sel,
  output logic [1:0] E_fwd_rs_sel,
  output logic [1:0] E_fwd_rt_sel,
  output logic       md_busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  // Writer trackers. W needs no tnew: anything in W is ready.
  logic [4:0]       e_dst, e_rs, e_rt, m_dst, w_dst;
  logic [1:0]       e_tnew, m_tnew;
  logic [CNT_W-1:0] md_cnt;

  logic rs_stall, rt_stall, md_stall;

  // A register number matches a stage only when non-zero; $0 never hazards.
  function automatic logic hit(input logic [4:0] dst, input logic [4:0] a);
    return (a != 5'd0) && (dst == a);
  endfunction

  // Operand with use time t must wait if a matching writer is not ready in time.
  function automatic logic data_wait(input logic [4:0] a, input logic [1:0] t,
                                     input logic [4:0] ed, input logic [1:0] et,
                                     input logic [4:0] md, input logic [1:0] mt);
    return (hit(ed, a) && (t < et)) || (hit(md, a) && (t < mt));
  endfunction

  // D-stage source: nearest matching stage wins; pending nearest means read RF
  // now and let the E-stage forward supply the right value later.
  function automatic logic [1:0] d_sel(input logic [4:0] a,
                                       input logic [4:0] ed, input logic [1:0] et,
                                       input logic [4:0] md, input logic [1:0] mt,
                                       input logic [4:0] wd);
    if (hit(ed, a))      return (et == 2'd0) ? 2'd1 : 2'd0;
    else if (hit(md, a)) return (mt == 2'd0) ? 2'd2 : 2'd0;
    else if (hit(wd, a)) return 2'd3;
    else                 return 2'd0;
  endfunction

  // E-stage source: M if it matches and is ready, else W; a pending M copy is
  // never bypassed in favour of an older W value.
  function automatic logic [1:0] e_sel(input logic [4:0] a,
                                       input logic [4:0] md, input logic [1:0] mt,
                                       input logic [4:0] wd);
    if (hit(md, a))      return (mt == 2'd0) ? 2'd1 : 2'd0;
    else if (hit(wd, a)) return 2'd2;
    else                 return 2'd0;
  endfunction

  // Stall and forwarding decode from tracker state and D inputs.
  always_comb begin
    md_busy      = (md_cnt != '0);
    rs_stall     = data_wait(D_rs_addr, D_rs_tuse, e_dst, e_tnew, m_dst, m_tnew);
    rt_stall     = data_wait(D_rt_addr, D_rt_tuse, e_dst, e_tnew, m_dst, m_tnew);
    md_stall     = (D_md_use || D_md_start) && md_busy;
    stall        = rs_stall || rt_stall || md_stall;
    D_fwd_rs_sel = d_sel(D_rs_addr, e_dst, e_tnew, m_dst, m_tnew, w_dst);
    D_fwd_rt_sel = d_sel(D_rt_addr, e_dst, e_tnew, m_dst, m_tnew, w_dst);
    E_fwd_rs_sel = e_sel(e_rs, m_dst, m_tnew, w_dst);
    E_fwd_rt_sel = e_sel(e_rt, m_dst, m_tnew, w_dst);
  end

  // Advance the writer trackers; a stall drops a bubble into E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_dst  <= '0;
      e_tnew <= '0;
      e_rs   <= '0;
      e_rt   <= '0;
      m_dst  <= '0;
      m_tnew <= '0;
      w_dst  <= '0;
    end else begin
      w_dst  <= m_dst;
      m_dst  <= e_dst;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
      if (stall) begin
        e_dst  <= '0;
        e_tnew <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end else begin
        e_dst  <= D_dst;
        e_tnew <= D_tnew;
        e_rs   <= D_rs_addr;
        e_rt   <= D_rt_addr;
      end
    end
  end

  // HI/LO occupancy countdown; a start only loads once it actually leaves D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (!stall && D_md_start) begin
      md_cnt <= D_md_div ? DIV_LD : MULT_LD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule
